// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: op codes, FSM states and the
// parity helper used by the single-step datapath.
package alu_pkg;

    localparam logic [3:0] OP_MOV  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_NOT  = 4'h4;
    localparam logic [3:0] OP_NOR  = 4'h5;
    localparam logic [3:0] OP_NAND = 4'h6;
    localparam logic [3:0] OP_XNOR = 4'h7;
    localparam logic [3:0] OP_ADD  = 4'h8;
    localparam logic [3:0] OP_ADC  = 4'h9;
    localparam logic [3:0] OP_SUB  = 4'hA;
    localparam logic [3:0] OP_SBC  = 4'hB;
    localparam logic [3:0] OP_SHL  = 4'hC;
    localparam logic [3:0] OP_RCC  = 4'hD;
    localparam logic [3:0] OP_ROT  = 4'hE;
    localparam logic [3:0] OP_ASH  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Zero-extension leaves parity unchanged, so any width up to 64 bits fits.
    function automatic logic parity64(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/alu_step.sv
// Single combinational ALU step: applies one of the 16 rules to (w, b, c).
// Shift ops C-F move exactly one bit per evaluation.
module alu_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic             xy,
    input  logic [WIDTH-1:0] w,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] w_next,
    output logic             c_next
);

    localparam int M = WIDTH - 1;

    logic [WIDTH-1:0] addend_s;
    logic             carry_in_s;
    logic [WIDTH:0]   sum_s;
    logic             fill_s;
    logic [WIDTH-1:0] shifted_s;
    logic             par_s;

    assign par_s = parity64(64'(w));

    // Adder operand selection: subtraction is a + ~b + carry.
    always_comb begin
        addend_s   = b;
        carry_in_s = 1'b0;
        case (op)
            OP_ADD:  begin addend_s = b;  carry_in_s = 1'b0; end
            OP_ADC:  begin addend_s = b;  carry_in_s = c;    end
            OP_SUB:  begin addend_s = ~b; carry_in_s = 1'b1; end
            OP_SBC:  begin addend_s = ~b; carry_in_s = c;    end
            default: begin addend_s = b;  carry_in_s = 1'b0; end
        endcase
        sum_s = {1'b0, w} + {1'b0, addend_s} + (WIDTH+1)'(carry_in_s);
    end

    // Bit entering the vacated position for the shift family.
    always_comb begin
        fill_s = 1'b0;
        case (op)
            OP_SHL:  fill_s = 1'b0;
            OP_RCC:  fill_s = c;
            OP_ROT:  fill_s = w[0];
            OP_ASH:  fill_s = w[M];
            default: fill_s = 1'b0;
        endcase
        if (xy) begin
            shifted_s = {fill_s, w[M:1]};
        end else begin
            shifted_s = {w[M-1:0], fill_s};
        end
    end

    // Result and carry selection for all 16 ops.
    always_comb begin
        w_next = w;
        c_next = c;
        case (op)
            OP_MOV:  begin w_next = b;          c_next = w[M];            end
            OP_OR:   begin w_next = w | b;      c_next = c;               end
            OP_AND:  begin w_next = w & b;      c_next = (w != '0);       end
            OP_XOR:  begin w_next = w ^ b;      c_next = par_s;           end
            OP_NOT:  begin w_next = ~b;         c_next = ~w[M];           end
            OP_NOR:  begin w_next = ~(w | b);   c_next = ~c;              end
            OP_NAND: begin w_next = ~(w & b);   c_next = (w == '0);       end
            OP_XNOR: begin w_next = ~(w ^ b);   c_next = ~par_s;          end
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                w_next = sum_s[WIDTH-1:0];
                c_next = sum_s[WIDTH];
            end
            OP_SHL, OP_RCC, OP_ROT, OP_ASH: begin
                w_next = shifted_s;
                c_next = xy ? w[0] : w[M];
            end
            default: begin w_next = w;          c_next = c;               end
        endcase
    end

endmodule

// File: rtl/alu_iter.sv
// Sequential ALU with start/ready/valid handshake, internal carry flag and
// multi-bit shifts executed one bit per cycle through alu_step.
module alu_iter
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             xy,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [CW-1:0]    cnt,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             cflag
);

    state_t           state_r;
    logic [3:0]       op_r;
    logic             xy_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] w_r;
    logic             c_r;
    logic [CW-1:0]    rem_r;
    logic [WIDTH-1:0] q_r;
    logic             cout_r;
    logic             cflag_r;
    logic             valid_r;
    logic             ready_r;

    logic [3:0]       op_s;
    logic             xy_s;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] b_s;
    logic             c_s;
    logic [WIDTH-1:0] w_next_s;
    logic             c_next_s;
    logic             accept_s;
    logic             is_shift_s;

    assign accept_s   = start && ready_r;
    assign is_shift_s = (op[3:2] == 2'b11);

    // In IDLE the first step runs straight off the inputs so short ops finish in one cycle.
    always_comb begin
        if (state_r == ST_IDLE) begin
            op_s = op;
            xy_s = xy;
            w_s  = a;
            b_s  = b;
            c_s  = cflag_r;
        end else begin
            op_s = op_r;
            xy_s = xy_r;
            w_s  = w_r;
            b_s  = b_r;
            c_s  = c_r;
        end
    end

    alu_step #(.WIDTH(WIDTH)) u_step (
        .op     (op_s),
        .xy     (xy_s),
        .w      (w_s),
        .b      (b_s),
        .c      (c_s),
        .w_next (w_next_s),
        .c_next (c_next_s)
    );

    // Control FSM with operand capture, iteration count and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            op_r    <= 4'h0;
            xy_r    <= 1'b0;
            b_r     <= '0;
            w_r     <= '0;
            c_r     <= 1'b0;
            rem_r   <= '0;
            q_r     <= '0;
            cout_r  <= 1'b0;
            cflag_r <= 1'b0;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    valid_r <= 1'b0;
                    if (accept_s) begin
                        op_r    <= op;
                        xy_r    <= xy;
                        b_r     <= b;
                        ready_r <= 1'b0;
                        if (is_shift_s && (cnt == CW'(0))) begin
                            q_r     <= a;
                            cout_r  <= cflag_r;
                            valid_r <= 1'b1;
                            state_r <= ST_DONE;
                        end else if (is_shift_s && (cnt > CW'(1))) begin
                            w_r     <= w_next_s;
                            c_r     <= c_next_s;
                            rem_r   <= cnt - CW'(1);
                            state_r <= ST_ITER;
                        end else begin
                            q_r     <= w_next_s;
                            cout_r  <= c_next_s;
                            cflag_r <= c_next_s;
                            valid_r <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_ITER: begin
                    w_r   <= w_next_s;
                    c_r   <= c_next_s;
                    rem_r <= rem_r - CW'(1);
                    if (rem_r == CW'(1)) begin
                        q_r     <= w_next_s;
                        cout_r  <= c_next_s;
                        cflag_r <= c_next_s;
                        valid_r <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        valid_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready = ready_r;
    assign valid = valid_r;
    assign q     = q_r;
    assign cout  = cout_r;
    assign cflag = cflag_r;

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised, sequential successor to the 8-bit single-cycle ALU. It keeps the same 16-op encoding and xy shift-direction semantics.
- Adds a configurable datapath width and an internal carry-flag register that replaces the external cin.
- Adds multi-bit shifts/rotates executed iteratively, one bit per cycle.
- Sits between the register file and writeback. The CPU sequencer drives it with a start/ready/valid handshake.

Parameters:
- WIDTH, 8, datapath width in bits (≥2).
- Derived localparam CW = clog2(WIDTH), the shift-count width (not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- op  in  4  operation code, same encoding as the 8-bit ALU.
- xy  in  1  shift direction for ops C-F: 0=left, 1=right.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cnt  in  CW  shift count for ops C-F; ignored for ops 0-B.
- ready  out  1  high when IDLE and able to accept start.
- valid  out  1  one-cycle pulse; q/cout are valid this cycle.
- q  out  WIDTH  result, registered, held until the next valid.
- cout  out  1  carry result, registered, held until the next valid.
- cflag  out  1  stored carry flag, used as cin.

Behaviour:
- Reset values: q=0, cout=0, cflag=0, valid=0, ready=1, state=IDLE. Reset mid-operation aborts it: no valid is issued and cflag is cleared.
- Capture: on an accepted start (start & ready), latch op, xy, a, b and cnt. Inputs are don't-care afterwards. start while ready=0 is ignored (no queueing).
- cin is always the cflag value at the moment of acceptance, or the running carry during iteration.
- On every valid: cflag <= cout.
- States: IDLE, ITER, DONE.
  - IDLE -> ITER on accept, when op is C-F and cnt>1.
  - IDLE -> DONE on accept otherwise.
  - ITER decrements the remaining count each cycle and goes to DONE after the final step.
  - DONE: valid=1 for exactly one cycle, then IDLE; ready=1 again in that same cycle as IDLE.
- Latency, accept to valid: 1 cycle for ops 0-B and for C-F with cnt≤1; cnt cycles for C-F with cnt≥2.
- Ops 0-B, single step (M = WIDTH-1; "parity" is the XOR of all bits of a):
  - 0: q=b, cout=a[M].
  - 1: q=a|b, cout=cin.
  - 2: q=a&b, cout=(a≠0).
  - 3: q=a^b, cout=parity(a).
  - 4: q=~b, cout=~a[M].
  - 5: q=~(a|b), cout=~cin.
  - 6: q=~(a&b), cout=(a==0).
  - 7: q=~(a^b), cout=~parity(a).
  - 8: {cout,q}=a+b.
  - 9: {cout,q}=a+b+cin.
  - A: {cout,q}=a+~b+1.
  - B: {cout,q}=a+~b+cin.
  - Sums are WIDTH+1 bits wide; the MSB is cout.
- Ops C-F, iterative: w starts at a and c starts at cin. Each step applies the single-bit rule below to the current w and c, then updates both.
  - Per step, every op sets c_next = w[M] for left, w[0] for right.
  - C, logical: left w<<1; right w>>1.
  - D, rotate through carry: left (w<<1)|c; right (w>>1)|(c<<M).
  - E: left (w<<1)|w[0]; right (w>>1)|(w[0]<<M).
  - F: left (w<<1)|w[M]; right (w>>1)|(w[M]<<M), i.e. arithmetic right.
  - Final result: q=w, cout=c.
- cnt=0 for C-F: q=a, cout=cflag (unchanged), latency 1.
- With WIDTH=8 and cnt=1, results match the original 8-bit ALU bit-for-bit, given cin=cflag.

Decomposition:
- Shared package alu_pkg holds:
  - op-code localparams: OP_MOV=0, OP_OR, OP_AND, OP_XOR, OP_NOT, OP_NOR, OP_NAND, OP_XNOR, OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_SHL, OP_RCC, OP_ROT, OP_ASH;
  - state encodings for IDLE, ITER and DONE.
- One sub-module, alu_step: purely combinational, (op, xy, w, b, c) -> (w_next, c_next). It implements all 16 single-step rules.
- alu_iter wraps alu_step with the FSM, the count register, and the w/c/cflag registers.

Test Plan:
- WIDTH=8, after reset, op=8, a=0xF0, b=0x20 -> valid 1 cycle after accept, q=0x10, cout=1, cflag=1.
- Next op=9, a=0x01, b=0x01 -> q=0x03, cout=0; confirms cin comes from cflag.
- WIDTH=8, cflag=1, op=D, xy=0, a=0x80, cnt=3 -> valid 3 cycles after accept, q=0x06, cout=0; ready low during ITER, and a start pulse then is ignored.
- WIDTH=16, op=F, xy=1, a=0x8001, cnt=4 -> q=0xF800, cout=0, latency 4.
- op=C, cnt=0, a=0x5A, cflag=1 -> q=0x5A, cout=1, latency 1.
- Assert rst during ITER (op=E, cnt=7) -> no valid, ready=1 and cflag=0 the next cycle. Then a randomised compare of 2^16 vectors at WIDTH=8, cnt=1, against an ALU reference model.
